delay_allocator: RTL and testbench
==================================

DELAY_ALLOCATOR -- requirements
Module: delay_allocator

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 16, meaning the word-address width of the shared delay memory.
REQ-002 SHALL have parameter N_DELAYS, default 16, meaning the maximum number of delay descriptors per pipeline.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning the delay memory word width.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 alloc_req  input  2  one-cycle request pulse; bit p selects pipeline p.
REQ-007 delay_size  input  32  requested buffer length in words; valid with alloc_req.
REQ-008 init_delay  input  32  initial read offset in words; valid with alloc_req.
REQ-009 pipeline_full_reset  input  2  one-cycle pulse; frees all of pipeline p's allocations.
REQ-010 busy  output  2  bit p high while pipeline p's allocation is in progress.
REQ-011 desc_we  output  1  one-cycle descriptor-table write strobe.
REQ-012 desc_pipeline  output  1  target pipeline of the descriptor write.
REQ-013 desc_index  output  clog2(N_DELAYS)  descriptor slot within that pipeline.
REQ-014 desc_base, desc_size, desc_init  output  MEM_ADDR_WIDTH each  absolute base address, length and initial offset.
REQ-015 clr_we, clr_addr, clr_data  output  1 / MEM_ADDR_WIDTH / DATA_WIDTH  delay-memory zero-fill write port.
REQ-016 err_overflow, err_size, err_busy, err_table_full  output  1 each  one-cycle error pulses.

Function
REQ-017 Memory SHALL be split into two regions of HALF = 2^(MEM_ADDR_WIDTH-1) words; pipeline p owns [p*HALF, p*HALF+HALF-1].
REQ-018 Per pipeline, a bump pointer next_free[p] (0..HALF) and a slot count count[p] (0..N_DELAYS) SHALL be kept.
REQ-019 FSM states SHALL be IDLE, CHECK, DESC, CLEAR; a request is accepted only in IDLE.
REQ-020 Request at cycle N in IDLE: operands and pipeline latched, state CHECK at N+1, busy[p] high from N+1.
REQ-021 CHECK, priority order: delay_size==0 or init_delay>=delay_size -> err_size; count[p]==N_DELAYS -> err_table_full; delay_size > HALF-next_free[p] -> err_overflow; any error -> IDLE, no state change.
REQ-022 Otherwise DESC at N+2: desc_we=1, desc_index=count[p], desc_base=p*HALF+next_free[p], desc_size and desc_init = low MEM_ADDR_WIDTH bits of the latched operands.
REQ-023 In DESC, next_free[p] += delay_size and count[p] += 1.
REQ-024 CLEAR SHALL issue clr_we=1, clr_data=0 for addresses desc_base .. desc_base+size-1, one word per cycle, from N+3 to N+2+size.
REQ-025 After the last clear word, state IDLE and busy[p] low on the next cycle.
REQ-026 Both alloc_req bits in the same IDLE cycle: pipeline 0 served, err_busy pulsed for pipeline 1.
REQ-027 Any alloc_req while not IDLE SHALL be dropped with err_busy at N+1.
REQ-028 pipeline_full_reset[p] SHALL zero next_free[p] and count[p] next cycle; if the in-flight allocation targets p, abort to IDLE immediately, busy[p] low, no further desc_we or clr_we.
REQ-029 full_reset[p] coincident with alloc_req[p] in IDLE: reset wins, request dropped without error.
REQ-030 full_reset of the other pipeline SHALL NOT disturb an in-flight allocation.
REQ-031 Exact-fit allocation (size == remaining words) SHALL succeed and leave next_free[p]==HALF.

Reset
REQ-032 On reset: state IDLE; next_free, count, busy, desc_we, clr_we and all err_* zero; desc_* and clr_addr zero.
REQ-033 Reset mid-CLEAR SHALL stop clear writes on the following cycle.

Structure
REQ-034 State encodings and error-priority constants SHALL live in the shared package/header alongside the controller command codes.
REQ-035 One sub-module, delay_region_ctr (bump pointer plus slot counter for one pipeline), instantiated twice, is natural.

Verification
REQ-036 alloc_req=01, size=4, init=2 -> desc_we at N+2 with base 0, size 4, init 2; clr_we at addrs 0..3 over N+3..N+6; busy[0] low at N+7.
REQ-037 Pipeline 1, size 8 then size 3 -> bases HALF and HALF+8, desc_index 0 and 1.
REQ-038 size=0 -> err_size at N+1; init=5, size=5 -> err_size; no desc_we in either case.
REQ-039 MEM_ADDR_WIDTH=6 (HALF=32): sizes 20 then 12 succeed, third size 1 -> err_overflow; N_DELAYS+1 size-1 requests -> err_table_full on the last.
REQ-040 size=10, full_reset[0] at N+5 -> clr_we stops, busy[0] low at N+6; next alloc gets base 0.
REQ-041 alloc_req=11 in one cycle -> pipeline 0 served, err_busy at N+1, pipeline 1 counters unchanged.

Source files
------------

// File: rtl/delay_allocator_pkg.sv
// Shared constants and types for the delay allocator: controller state codes,
// error-priority codes, region-counter command codes, the error pulse bundle
// and the request classification helper.
package delay_allocator_pkg;

  // Controller states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DESC  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  // Request check outcome, listed in decreasing priority after ERR_NONE
  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_SIZE       = 2'd1;
  localparam logic [1:0] ERR_TABLE_FULL = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW   = 2'd3;

  // Commands driven into each per-pipeline region counter
  localparam logic [1:0] CTR_HOLD   = 2'd0;
  localparam logic [1:0] CTR_COMMIT = 2'd1;
  localparam logic [1:0] CTR_CLEAR  = 2'd2;

  typedef struct packed {
    logic overflow;
    logic size;
    logic busy;
    logic table_full;
  } err_t;

  // Classify a request against the target region; room = words left in region.
  function automatic logic [1:0] classify_req(input logic [31:0] size,
                                              input logic [31:0] init,
                                              input logic        table_full,
                                              input logic [32:0] room);
    if (size == 32'd0 || init >= size) return ERR_SIZE;
    if (table_full)                    return ERR_TABLE_FULL;
    if ({1'b0, size} > room)           return ERR_OVERFLOW;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/delay_region_ctr.sv
// Bump pointer and descriptor slot counter for one pipeline's memory region.
// Ports: clk, reset (sync, active-high), cmd (hold/commit/clear), add (words
// to bump on commit), next_free (first unused word offset), count (slots used).
module delay_region_ctr #(
  parameter int unsigned AW = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] add,
  output logic [AW-1:0] next_free,
  output logic [CW-1:0] count
);
  import delay_allocator_pkg::*;

  // Clear has priority so a full reset wins over a same-cycle commit
  always_ff @(posedge clk) begin
    if (reset || cmd == CTR_CLEAR) begin
      next_free <= '0;
      count     <= '0;
    end else if (cmd == CTR_COMMIT) begin
      next_free <= next_free + add;
      count     <= count + CW'(1);
    end
  end

endmodule

// File: rtl/delay_allocator.sv
// Bump allocator for delay buffers in a memory shared by two pipelines. Each
// pipeline owns one half of the memory; an accepted request writes a
// descriptor and then zero-fills the new buffer one word per cycle.
// Ports: alloc_req/delay_size/init_delay request a buffer; pipeline_full_reset
// frees a pipeline's region; busy flags the in-flight pipeline; desc_* is the
// descriptor-table write port; clr_* is the memory zero-fill port; err_* are
// one-cycle error pulses.
module delay_allocator #(
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned N_DELAYS       = 16,
  parameter int unsigned DATA_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    alloc_req,
  input  logic [31:0]                   delay_size,
  input  logic [31:0]                   init_delay,
  input  logic [1:0]                    pipeline_full_reset,
  output logic [1:0]                    busy,
  output logic                          desc_we,
  output logic                          desc_pipeline,
  output logic [$clog2(N_DELAYS)-1:0]   desc_index,
  output logic [MEM_ADDR_WIDTH-1:0]     desc_base,
  output logic [MEM_ADDR_WIDTH-1:0]     desc_size,
  output logic [MEM_ADDR_WIDTH-1:0]     desc_init,
  output logic                          clr_we,
  output logic [MEM_ADDR_WIDTH-1:0]     clr_addr,
  output logic [DATA_WIDTH-1:0]         clr_data,
  output logic                          err_overflow,
  output logic                          err_size,
  output logic                          err_busy,
  output logic                          err_table_full
);
  import delay_allocator_pkg::*;

  localparam int unsigned AW   = MEM_ADDR_WIDTH;
  localparam int unsigned IW   = $clog2(N_DELAYS);
  localparam int unsigned CW   = $clog2(N_DELAYS + 1);
  localparam int unsigned HALF = 2 ** (AW - 1);

  logic [1:0]          state_q, state_d;
  logic                pipe_q, pipe_d;
  logic [AW-1:0]       size_q, size_d;
  logic [AW-1:0]       init_q, init_d;
  logic [1:0]          code_q, code_d;
  logic [AW-1:0]       rem_q, rem_d;
  logic [1:0]          busy_q, busy_d;
  err_t                err_q, err_d;
  logic                desc_we_q, desc_we_d;
  logic                desc_pipeline_q, desc_pipeline_d;
  logic [IW-1:0]       desc_index_q, desc_index_d;
  logic [AW-1:0]       desc_base_q, desc_base_d;
  logic [AW-1:0]       desc_size_q, desc_size_d;
  logic [AW-1:0]       desc_init_q, desc_init_d;
  logic                clr_we_q, clr_we_d;
  logic [AW-1:0]       clr_addr_q, clr_addr_d;

  logic [1:0][AW-1:0]  nf;
  logic [1:0][CW-1:0]  cnt;
  logic                sel, idx, abort, full;
  logic [32:0]         room;
  logic [1:0]          code;

  // One bump pointer / slot counter per pipeline region
  for (genvar p = 0; p < 2; p++) begin : g_region
    logic [1:0] cmd;
    always_comb begin
      cmd = CTR_HOLD;
      if (pipeline_full_reset[p])                    cmd = CTR_CLEAR;
      else if (state_q == S_DESC && pipe_q == 1'(p)) cmd = CTR_COMMIT;
    end
    delay_region_ctr #(.AW(AW), .CW(CW)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .cmd       (cmd),
      .add       (size_q),
      .next_free (nf[p]),
      .count     (cnt[p])
    );
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    pipe_d          = pipe_q;
    size_d          = size_q;
    init_d          = init_q;
    code_d          = code_q;
    rem_d           = rem_q;
    busy_d          = busy_q;
    err_d           = '0;
    desc_we_d       = 1'b0;
    desc_pipeline_d = desc_pipeline_q;
    desc_index_d    = desc_index_q;
    desc_base_d     = desc_base_q;
    desc_size_d     = desc_size_q;
    desc_init_d     = desc_init_q;
    clr_we_d        = 1'b0;
    clr_addr_d      = clr_addr_q;
    code            = ERR_NONE;

    // Pipeline 0 wins a simultaneous request
    sel   = alloc_req[0] ? 1'b0 : 1'b1;
    idx   = (state_q == S_IDLE) ? sel : pipe_q;
    room  = 33'(HALF) - 33'(nf[idx]);
    full  = (cnt[idx] == CW'(N_DELAYS));
    abort = (state_q != S_IDLE) && pipeline_full_reset[pipe_q];

    case (state_q)
      S_IDLE: begin
        if (alloc_req != 2'b00) begin
          // The losing pipeline 1 request is reported unless its own reset drops it
          err_d.busy = alloc_req[0] & alloc_req[1] & ~pipeline_full_reset[1];
          if (!pipeline_full_reset[sel]) begin
            code             = classify_req(delay_size, init_delay, full, room);
            state_d          = S_CHECK;
            pipe_d           = sel;
            size_d           = AW'(delay_size);
            init_d           = AW'(init_delay);
            code_d           = code;
            busy_d           = sel ? 2'b10 : 2'b01;
            err_d.size       = (code == ERR_SIZE);
            err_d.table_full = (code == ERR_TABLE_FULL);
            err_d.overflow   = (code == ERR_OVERFLOW);
          end
        end
      end
      S_CHECK: begin
        if (abort || code_q != ERR_NONE) begin
          state_d = S_IDLE;
        end else begin
          state_d         = S_DESC;
          desc_we_d       = 1'b1;
          desc_pipeline_d = pipe_q;
          desc_index_d    = IW'(cnt[idx]);
          desc_base_d     = {pipe_q, nf[idx][AW-2:0]};
          desc_size_d     = size_q;
          desc_init_d     = init_q;
        end
      end
      S_DESC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_CLEAR;
          clr_we_d   = 1'b1;
          clr_addr_d = desc_base_q;
          rem_d      = size_q - AW'(1);
        end
      end
      S_CLEAR: begin
        if (abort || rem_q == '0) begin
          state_d = S_IDLE;
        end else begin
          clr_we_d   = 1'b1;
          clr_addr_d = clr_addr_q + AW'(1);
          rem_d      = rem_q - AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && alloc_req != 2'b00) err_d.busy = 1'b1;
    if (state_d == S_IDLE) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pipe_q          <= 1'b0;
      size_q          <= '0;
      init_q          <= '0;
      code_q          <= ERR_NONE;
      rem_q           <= '0;
      busy_q          <= '0;
      err_q           <= '0;
      desc_we_q       <= 1'b0;
      desc_pipeline_q <= 1'b0;
      desc_index_q    <= '0;
      desc_base_q     <= '0;
      desc_size_q     <= '0;
      desc_init_q     <= '0;
      clr_we_q        <= 1'b0;
      clr_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      pipe_q          <= pipe_d;
      size_q          <= size_d;
      init_q          <= init_d;
      code_q          <= code_d;
      rem_q           <= rem_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      desc_we_q       <= desc_we_d;
      desc_pipeline_q <= desc_pipeline_d;
      desc_index_q    <= desc_index_d;
      desc_base_q     <= desc_base_d;
      desc_size_q     <= desc_size_d;
      desc_init_q     <= desc_init_d;
      clr_we_q        <= clr_we_d;
      clr_addr_q      <= clr_addr_d;
    end
  end

  assign busy           = busy_q;
  assign desc_we        = desc_we_q;
  assign desc_pipeline  = desc_pipeline_q;
  assign desc_index     = desc_index_q;
  assign desc_base      = desc_base_q;
  assign desc_size      = desc_size_q;
  assign desc_init      = desc_init_q;
  assign clr_we         = clr_we_q;
  assign clr_addr       = clr_addr_q;
  assign clr_data       = DATA_WIDTH'(0);
  assign err_overflow   = err_q.overflow;
  assign err_size       = err_q.size;
  assign err_busy       = err_q.busy;
  assign err_table_full = err_q.table_full;

endmodule

// File: tb/tb_delay_allocator.sv
// Bench for delay_allocator with a small memory (HALF = 32 words, 4 slots).
// A transaction-timeline model predicts every output each cycle; directed
// sequences add literal expectations, then randomized traffic follows.
module tb_delay_allocator;

  localparam int AW   = 6;
  localparam int ND   = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;
  localparam int HALF = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    alloc_req;
  logic [31:0]   delay_size;
  logic [31:0]   init_delay;
  logic [1:0]    fr;
  logic [1:0]    busy;
  logic          desc_we;
  logic          desc_pipeline;
  logic [IW-1:0] desc_index;
  logic [AW-1:0] desc_base;
  logic [AW-1:0] desc_size;
  logic [AW-1:0] desc_init;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_data;
  logic          err_overflow;
  logic          err_size;
  logic          err_busy;
  logic          err_table_full;

  delay_allocator #(.MEM_ADDR_WIDTH(AW), .N_DELAYS(ND), .DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .alloc_req           (alloc_req),
    .delay_size          (delay_size),
    .init_delay          (init_delay),
    .pipeline_full_reset (fr),
    .busy                (busy),
    .desc_we             (desc_we),
    .desc_pipeline       (desc_pipeline),
    .desc_index          (desc_index),
    .desc_base           (desc_base),
    .desc_size           (desc_size),
    .desc_init           (desc_init),
    .clr_we              (clr_we),
    .clr_addr            (clr_addr),
    .clr_data            (clr_data),
    .err_overflow        (err_overflow),
    .err_size            (err_size),
    .err_busy            (err_busy),
    .err_table_full      (err_table_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One allocation is tracked as a timeline: t counts cycles since acceptance.
  // t=1 error pulses, t=2 descriptor write, t=3..2+size zero-fill words.
  bit      mvalid = 0;
  bit      act = 0;
  bit      aerr;
  int      ap, t, abase, aidx;
  longint  asz, ainit;
  int      nf[2];
  int      cnt[2];
  logic [1:0] e_busy;
  bit      e_we, e_clr, e_eo, e_es, e_eb, e_et;
  int      e_pipe, e_idx, e_base, e_addr;
  longint  e_size, e_init;

  always @(posedge clk) begin
    bit     was;
    int     told, sel;
    longint sz, in;
    e_eo = 0; e_es = 0; e_eb = 0; e_et = 0; e_we = 0; e_clr = 0;
    if (reset) begin
      mvalid = 1; act = 0; e_busy = 2'b00;
      nf[0] = 0; nf[1] = 0; cnt[0] = 0; cnt[1] = 0;
    end else begin
      was = act;
      if (act) begin
        told = t;
        if (fr[ap]) act = 0;
        else begin
          if (told == 2) begin
            nf[ap] += int'(asz);
            cnt[ap]++;
          end
          if ((told == 1 && aerr) || told == 2 + asz) act = 0;
          t = told + 1;
        end
      end
      for (int p = 0; p < 2; p++) if (fr[p]) begin nf[p] = 0; cnt[p] = 0; end
      if (alloc_req != 2'b00) begin
        if (was) e_eb = 1;
        else begin
          sel = alloc_req[0] ? 0 : 1;
          if (alloc_req == 2'b11 && !fr[1]) e_eb = 1;
          if (!fr[sel]) begin
            sz = longint'(delay_size);
            in = longint'(init_delay);
            if (sz == 0 || in >= sz) e_es = 1;
            else if (cnt[sel] == ND) e_et = 1;
            else if (sz > HALF - nf[sel]) e_eo = 1;
            aerr  = e_es | e_et | e_eo;
            act   = 1; ap = sel; t = 1;
            asz   = sz; ainit = in;
            abase = sel * HALF + nf[sel];
            aidx  = cnt[sel];
          end
        end
      end
      if (act && t == 2) begin
        e_we = 1; e_pipe = ap; e_idx = aidx; e_base = abase;
        e_size = asz; e_init = ainit;
      end
      if (act && t >= 3 && t <= 2 + asz) begin
        e_clr = 1; e_addr = abase + t - 3;
      end
      e_busy = act ? (ap == 1 ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("desc_we", 64'(desc_we), 64'(e_we));
      if (e_we) begin
        chk("desc_pipeline", 64'(desc_pipeline), 64'(e_pipe));
        chk("desc_index", 64'(desc_index), 64'(e_idx));
        chk("desc_base", 64'(desc_base), 64'(e_base));
        chk("desc_size", 64'(desc_size), 64'(e_size));
        chk("desc_init", 64'(desc_init), 64'(e_init));
      end
      chk("clr_we", 64'(clr_we), 64'(e_clr));
      if (e_clr) begin
        chk("clr_addr", 64'(clr_addr), 64'(e_addr));
        chk("clr_data", 64'(clr_data), 64'd0);
      end
      chk("err_size", 64'(err_size), 64'(e_es));
      chk("err_table_full", 64'(err_table_full), 64'(e_et));
      chk("err_overflow", 64'(err_overflow), 64'(e_eo));
      chk("err_busy", 64'(err_busy), 64'(e_eb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Pulse a request for one cycle; returns in the cycle after the request.
  task automatic req(input logic [1:0] r, input logic [31:0] s, input logic [31:0] i);
    alloc_req = r; delay_size = s; init_delay = i;
    tick(1);
    alloc_req = 2'b00; delay_size = $urandom; init_delay = $urandom;
  endtask

  initial begin
    reset = 1'b1; alloc_req = 2'b00; fr = 2'b00; delay_size = '0; init_delay = '0;
    tick(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_desc_base", 64'(desc_base), 64'd0);
    chk("rst_clr_addr", 64'(clr_addr), 64'd0);
    chk("rst_clr_we", 64'(clr_we), 64'd0);
    reset = 1'b0;
    tick(1);

    // Basic allocation on pipeline 0
    req(2'b01, 4, 2);
    chk("a_busy_n1", 64'(busy), 64'd1);
    tick(1);
    chk("a_desc_we", 64'(desc_we), 64'd1);
    chk("a_desc_base", 64'(desc_base), 64'd0);
    chk("a_desc_size", 64'(desc_size), 64'd4);
    chk("a_desc_init", 64'(desc_init), 64'd2);
    tick(1);
    chk("a_clr_first", 64'(clr_addr), 64'd0);
    chk("a_clr_we", 64'(clr_we), 64'd1);
    tick(3);
    chk("a_clr_last", 64'(clr_addr), 64'd3);
    tick(1);
    chk("a_busy_done", 64'(busy), 64'd0);
    chk("a_clr_off", 64'(clr_we), 64'd0);

    // Pipeline 1 back-to-back allocations
    req(2'b10, 8, 0);
    tick(1);
    chk("p1_base0", 64'(desc_base), 64'd32);
    chk("p1_idx0", 64'(desc_index), 64'd0);
    tick(9);
    req(2'b10, 3, 1);
    tick(1);
    chk("p1_base1", 64'(desc_base), 64'd40);
    chk("p1_idx1", 64'(desc_index), 64'd1);
    tick(6);

    // Size errors
    req(2'b01, 0, 0);
    chk("sz0_err", 64'(err_size), 64'd1);
    tick(1);
    chk("sz0_nowe", 64'(desc_we), 64'd0);
    tick(1);
    req(2'b01, 5, 5);
    chk("init_eq_err", 64'(err_size), 64'd1);
    tick(1);
    chk("init_eq_nowe", 64'(desc_we), 64'd0);
    tick(1);

    // Exact fit then overflow
    do_reset();
    req(2'b01, 20, 0);
    tick(22);
    req(2'b01, 12, 11);
    tick(1);
    chk("fit_base", 64'(desc_base), 64'd20);
    tick(13);
    req(2'b01, 1, 0);
    chk("ovf_err", 64'(err_overflow), 64'd1);
    tick(2);

    // Table full after N_DELAYS allocations
    do_reset();
    for (int k = 0; k <= ND; k++) begin
      req(2'b10, 1, 0);
      if (k == ND) begin
        chk("tfull_err", 64'(err_table_full), 64'd1);
        tick(2);
      end else begin
        tick(1);
        chk("tfull_idx", 64'(desc_index), 64'(k));
        tick(2);
      end
    end

    // Full reset aborts an in-flight clear
    do_reset();
    req(2'b01, 10, 0);
    tick(4);
    chk("fr_clr_before", 64'(clr_we), 64'd1);
    fr = 2'b01;
    tick(1);
    fr = 2'b00;
    chk("fr_clr_stop", 64'(clr_we), 64'd0);
    chk("fr_busy_low", 64'(busy), 64'd0);
    req(2'b01, 6, 0);
    tick(1);
    chk("fr_rebase", 64'(desc_base), 64'd0);
    tick(8);

    // Simultaneous requests
    req(2'b11, 5, 0);
    chk("both_errbusy", 64'(err_busy), 64'd1);
    chk("both_busy", 64'(busy), 64'd1);
    tick(7);
    req(2'b10, 2, 0);
    tick(1);
    chk("both_p1_base", 64'(desc_base), 64'd32);
    tick(3);

    // Reset in the middle of a clear
    req(2'b01, 8, 0);
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_clr", 64'(clr_we), 64'd0);
    reset = 1'b0;
    tick(1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      alloc_req = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      r = $urandom_range(0, 15);
      if (r == 0)      delay_size = 0;
      else if (r == 1) delay_size = $urandom;
      else if (r == 2) delay_size = 40;
      else             delay_size = 32'($urandom_range(1, 12));
      if (delay_size != 0 && $urandom_range(0, 7) != 0)
        init_delay = $urandom % delay_size;
      else
        init_delay = delay_size;
      fr    = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    alloc_req = 2'b00; fr = 2'b00; reset = 1'b0;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
